// File: rtl/alu_sequencer.sv
// Request-side sequencer for the 32-bit ripple-carry ALU: registers a command onto
// the ALU inputs, waits SETTLE_CYCLES for the result to settle, then returns it.
//
// state  | meaning
// IDLE   | ready for a command; ALU inputs hold the last command
// SETTLE | ALU inputs driven, counting down until the result is stable
// RESP   | captured result presented until the consumer takes it
module alu_sequencer #(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic [2:0]  i_cmd_op,
   input  logic [31:0] i_cmd_a,
   input  logic [31:0] i_cmd_b,
   input  logic        i_cmd_chain,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_result,
   output logic        o_rsp_overflow,
   output logic        o_rsp_zero,
   output logic [2:0]  o_alu_operation,
   output logic [31:0] o_alu_a,
   output logic [31:0] o_alu_b,
   input  logic [31:0] i_alu_out,
   input  logic        i_alu_overflow,
   output logic        o_ovf_sticky,
   input  logic        i_ovf_clear
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_accept;
   logic              w_capture;
   logic              w_cmd_ready;
   logic              w_rsp_valid;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_last;
   logic [31:0]       r_rsp_result;
   logic              r_rsp_overflow;
   logic              r_rsp_zero;
   logic [2:0]        r_alu_operation;
   logic [31:0]       r_alu_a;
   logic [31:0]       r_alu_b;
   logic              r_ovf_sticky;

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next      = S_IDLE;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_cmd_ready = 1'b0;
      w_rsp_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cmd_ready = 1'b1;
            w_accept    = i_cmd_valid;
            w_next      = i_cmd_valid ? S_SETTLE : S_IDLE;
         end
         S_SETTLE: begin
            w_capture = (r_cnt == '0);
            w_next    = w_capture ? S_RESP : S_SETTLE;
         end
         S_RESP: begin
            w_rsp_valid = 1'b1;
            w_next      = i_rsp_ready ? S_IDLE : S_RESP;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt           <= '0;
         r_last          <= '0;
         r_rsp_result    <= '0;
         r_rsp_overflow  <= 1'b0;
         r_rsp_zero      <= 1'b1;
         r_alu_operation <= '0;
         r_alu_a         <= '0;
         r_alu_b         <= '0;
         r_ovf_sticky    <= 1'b0;
      end else begin
         // cmd_* are only looked at on acceptance, so X while idle never lands in state
         if (w_accept) begin
            r_alu_operation <= i_cmd_op;
            r_alu_a         <= i_cmd_chain ? r_last : i_cmd_a;
            r_alu_b         <= i_cmd_b;
            r_cnt           <= CNT_W'(SETTLE_CYCLES - 1);
         end else if (r_state == S_SETTLE && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_capture) begin
            r_rsp_result   <= i_alu_out;
            r_rsp_overflow <= i_alu_overflow;
            r_rsp_zero     <= (i_alu_out == '0);
            r_last         <= i_alu_out;
         end
         // a fresh overflow outranks a simultaneous clear
         if (w_capture && i_alu_overflow) r_ovf_sticky <= 1'b1;
         else if (i_ovf_clear)            r_ovf_sticky <= 1'b0;
      end
   end

   assign o_cmd_ready     = w_cmd_ready;
   assign o_rsp_valid     = w_rsp_valid;
   assign o_rsp_result    = r_rsp_result;
   assign o_rsp_overflow  = r_rsp_overflow;
   assign o_rsp_zero      = r_rsp_zero;
   assign o_alu_operation = r_alu_operation;
   assign o_alu_a         = r_alu_a;
   assign o_alu_b         = r_alu_b;
   assign o_ovf_sticky    = r_ovf_sticky;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a 4-cycle instance for the main scenarios and a
// 1-cycle instance for the minimum-settle build, each wired to a behavioural ALU.
module tb_alu_sequencer;

   logic clk;
   int   total = 0;
   int   bad   = 0;

   logic        rst0, cv0, ch0, rr0, oc0;
   logic [2:0]  op0;
   logic [31:0] a0, b0;
   logic        cr0, rv0, ro0, rz0, st0;
   logic [31:0] res0, aa0, ab0, alu_out0;
   logic [2:0]  aop0;
   logic        alu_ovf0;

   logic        rst1, cv1, ch1, rr1, oc1;
   logic [2:0]  op1;
   logic [31:0] a1, b1;
   logic        cr1, rv1, ro1, rz1, st1;
   logic [31:0] res1, aa1, ab1, alu_out1;
   logic [2:0]  aop1;
   logic        alu_ovf1;

   function automatic logic [32:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] r;
      logic        v;
      v = 1'b0;
      case (op)
         3'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
         3'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
         3'd2: r = a ^ b;
         3'd3: r = {31'b0, $signed(a) < $signed(b)};
         3'd4: r = a & b;
         3'd5: r = ~(a & b);
         3'd6: r = ~(a | b);
         default: r = a | b;
      endcase
      return {v, r};
   endfunction

   assign {alu_ovf0, alu_out0} = alu_f(aop0, aa0, ab0);
   assign {alu_ovf1, alu_out1} = alu_f(aop1, aa1, ab1);

   alu_sequencer #(.SETTLE_CYCLES(4), .CNT_W(8)) u_dut0 (
      .i_clk(clk), .i_reset(rst0), .i_cmd_valid(cv0), .o_cmd_ready(cr0),
      .i_cmd_op(op0), .i_cmd_a(a0), .i_cmd_b(b0), .i_cmd_chain(ch0),
      .o_rsp_valid(rv0), .i_rsp_ready(rr0), .o_rsp_result(res0),
      .o_rsp_overflow(ro0), .o_rsp_zero(rz0), .o_alu_operation(aop0),
      .o_alu_a(aa0), .o_alu_b(ab0), .i_alu_out(alu_out0),
      .i_alu_overflow(alu_ovf0), .o_ovf_sticky(st0), .i_ovf_clear(oc0));

   alu_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
      .i_clk(clk), .i_reset(rst1), .i_cmd_valid(cv1), .o_cmd_ready(cr1),
      .i_cmd_op(op1), .i_cmd_a(a1), .i_cmd_b(b1), .i_cmd_chain(ch1),
      .o_rsp_valid(rv1), .i_rsp_ready(rr1), .o_rsp_result(res1),
      .o_rsp_overflow(ro1), .o_rsp_zero(rz1), .o_alu_operation(aop1),
      .o_alu_a(aa1), .o_alu_b(ab1), .i_alu_out(alu_out1),
      .i_alu_overflow(alu_ovf1), .o_ovf_sticky(st1), .i_ovf_clear(oc1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one command on dut0 from IDLE; lat = edges from acceptance to rsp_valid, -1 on timeout.
   task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic chain, output int lat);
      logic acc;
      logic rdy;
      int   n;
      acc = 1'b0; n = 0; lat = -1;
      cv0 = 1'b1; op0 = op; a0 = a; b0 = b; ch0 = chain; rr0 = 1'b0;
      for (int i = 0; i < 40 && lat < 0; i++) begin
         rdy = cr0;
         @(posedge clk); #1;
         if (acc) begin
            n++;
            if (rv0) lat = n;
         end
         if (!acc && rdy) begin
            acc = 1'b1;
            cv0 = 1'b0; op0 = 'x; a0 = 'x; b0 = 'x; ch0 = 'x;
         end
      end
   endtask

   task automatic consume();
      rr0 = 1'b1;
      @(posedge clk); #1;
      rr0 = 1'b0;
   endtask

   task automatic test_reset();
      rst0 = 1'b1; rst1 = 1'b1;
      cv0 = 1'b0; cv1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0; oc0 = 1'b0; oc1 = 1'b0;
      op0 = 'x; a0 = 'x; b0 = 'x; ch0 = 'x; op1 = 'x; a1 = 'x; b1 = 'x; ch1 = 'x;
      repeat (2) @(posedge clk);
      #1; rst0 = 1'b0; rst1 = 1'b0;
      total++; if ({cr0, rv0} !== 2'b10) begin bad++; $display("FAIL reset_hs: got %b want 10", {cr0, rv0}); end
      total++; if ({res0, ro0, rz0} !== {32'h0, 1'b0, 1'b1}) begin bad++; $display("FAIL reset_rsp: got %h %b %b want 0 0 1", res0, ro0, rz0); end
      total++; if ({aop0, aa0, ab0} !== 67'h0) begin bad++; $display("FAIL reset_alu: got %h %h %h want 0 0 0", aop0, aa0, ab0); end
      total++; if (st0 !== 1'b0) begin bad++; $display("FAIL reset_sticky: got %b want 0", st0); end
      @(posedge clk); #1;
      total++; if ({cr0, rv0, aa0} !== {2'b10, 32'h0}) begin bad++; $display("FAIL idle_x_inputs: got %b %b %h want 1 0 0", cr0, rv0, aa0); end
   endtask

   task automatic test_add_latency();
      cv0 = 1'b1; op0 = 3'd0; a0 = 32'd5; b0 = 32'd7; ch0 = 1'b0;
      @(posedge clk); #1;
      cv0 = 1'b0;
      total++; if ({aop0, aa0, ab0} !== {3'd0, 32'd5, 32'd7}) begin bad++; $display("FAIL add_drive: got %h %h %h want 0 5 7", aop0, aa0, ab0); end
      total++; if (cr0 !== 1'b0) begin bad++; $display("FAIL add_busy: got %b want 0", cr0); end
      for (int k = 1; k < 4; k++) begin
         @(posedge clk); #1;
         total++; if (rv0 !== 1'b0) begin bad++; $display("FAIL add_early_rsp edge %0d: got %b want 0", k, rv0); end
      end
      @(posedge clk); #1;
      total++; if ({rv0, res0, ro0, rz0} !== {1'b1, 32'd12, 1'b0, 1'b0}) begin bad++; $display("FAIL add_rsp: got %b %h %b %b want 1 c 0 0", rv0, res0, ro0, rz0); end
      consume();
      total++; if ({rv0, cr0} !== 2'b01) begin bad++; $display("FAIL add_done: got %b %b want 0 1", rv0, cr0); end
      total++; if ({res0, aa0, ab0} !== {32'd12, 32'd5, 32'd7}) begin bad++; $display("FAIL add_hold: got %h %h %h want c 5 7", res0, aa0, ab0); end
   endtask

   task automatic test_overflow_sticky();
      int lat;
      run_cmd(3'd1, 32'h8000_0000, 32'd1, 1'b0, lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL sub_latency: got %0d want 4", lat); end
      total++; if ({res0, ro0, st0} !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin bad++; $display("FAIL sub_ovf: got %h %b %b want 7fffffff 1 1", res0, ro0, st0); end
      consume();
      oc0 = 1'b1;
      @(posedge clk); #1;
      oc0 = 1'b0;
      total++; if (st0 !== 1'b0) begin bad++; $display("FAIL sticky_clear: got %b want 0", st0); end
      oc0 = 1'b1;
      run_cmd(3'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, lat);
      total++; if ({res0, ro0, st0} !== {32'h8000_0000, 1'b1, 1'b1}) begin bad++; $display("FAIL sticky_set_wins: got %h %b %b want 80000000 1 1", res0, ro0, st0); end
      oc0 = 1'b0;
      consume();
   endtask

   task automatic test_chain();
      int lat;
      run_cmd(3'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, lat);
      total++; if ({res0, ro0, rz0} !== {32'd1, 1'b0, 1'b0}) begin bad++; $display("FAIL slt: got %h %b %b want 1 0 0", res0, ro0, rz0); end
      consume();
      run_cmd(3'd1, 32'hDEAD_BEEF, 32'd1, 1'b1, lat);
      total++; if (aa0 !== 32'd1) begin bad++; $display("FAIL chain_a: got %h want 1", aa0); end
      total++; if ({res0, rz0} !== {32'd0, 1'b1}) begin bad++; $display("FAIL chain_rsp: got %h %b want 0 1", res0, rz0); end
      consume();
   endtask

   task automatic test_backpressure();
      int lat;
      int k;
      run_cmd(3'd0, 32'd3, 32'd4, 1'b0, lat);
      total++; if (res0 !== 32'd7) begin bad++; $display("FAIL bp_first: got %h want 7", res0); end
      cv0 = 1'b1; op0 = 3'd2; a0 = 32'hF0; b0 = 32'hFF; ch0 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         total++; if ({rv0, cr0, res0, aa0} !== {2'b10, 32'd7, 32'd3}) begin bad++; $display("FAIL bp_hold cyc %0d: got %b %b %h %h want 1 0 7 3", i, rv0, cr0, res0, aa0); end
      end
      rr0 = 1'b1;
      @(posedge clk); #1;
      rr0 = 1'b0;
      total++; if ({rv0, cr0, aa0} !== {2'b01, 32'd3}) begin bad++; $display("FAIL bp_release: got %b %b %h want 0 1 3", rv0, cr0, aa0); end
      @(posedge clk); #1;
      cv0 = 1'b0;
      total++; if ({cr0, aop0, aa0, ab0} !== {1'b0, 3'd2, 32'hF0, 32'hFF}) begin bad++; $display("FAIL bp_accept: got %b %h %h %h want 0 2 f0 ff", cr0, aop0, aa0, ab0); end
      k = 0;
      while (!rv0 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      total++; if ({k, res0} !== {32'd4, 32'h0F}) begin bad++; $display("FAIL bp_second: got lat %0d res %h want 4 f", k, res0); end
      consume();
   endtask

   task automatic test_reset_mid();
      int lat;
      run_cmd(3'd0, 32'd100, 32'd200, 1'b0, lat);
      total++; if ({res0, st0} !== {32'd300, 1'b1}) begin bad++; $display("FAIL pre_reset: got %h %b want 12c 1", res0, st0); end
      consume();
      cv0 = 1'b1; op0 = 3'd0; a0 = 32'd1; b0 = 32'd1; ch0 = 1'b0;
      @(posedge clk); #1;
      cv0 = 1'b0;
      @(posedge clk); #1;
      rst0 = 1'b1;
      @(posedge clk); #1;
      rst0 = 1'b0;
      total++; if ({cr0, rv0, res0, ro0, rz0} !== {2'b10, 32'd0, 2'b01}) begin bad++; $display("FAIL mid_reset_rsp: got %b %b %h %b %b want 1 0 0 0 1", cr0, rv0, res0, ro0, rz0); end
      total++; if ({aop0, aa0, ab0, st0} !== 68'h0) begin bad++; $display("FAIL mid_reset_alu: got %h %h %h %b want 0 0 0 0", aop0, aa0, ab0, st0); end
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         total++; if (rv0 !== 1'b0) begin bad++; $display("FAIL mid_reset_ghost cyc %0d: got %b want 0", i, rv0); end
      end
      run_cmd(3'd0, 32'h55, 32'd9, 1'b1, lat);
      total++; if ({aa0, res0} !== {32'd0, 32'd9}) begin bad++; $display("FAIL post_reset_chain: got %h %h want 0 9", aa0, res0); end
      consume();
   endtask

   task automatic test_settle_one();
      cv1 = 1'b1; op1 = 3'd6; a1 = 32'd0; b1 = 32'd0; ch1 = 1'b0;
      @(posedge clk); #1;
      cv1 = 1'b0;
      total++; if ({aop1, rv1} !== {3'd6, 1'b0}) begin bad++; $display("FAIL s1_accept: got %h %b want 6 0", aop1, rv1); end
      @(posedge clk); #1;
      total++; if ({rv1, res1, ro1, rz1} !== {1'b1, 32'hFFFF_FFFF, 2'b00}) begin bad++; $display("FAIL s1_rsp: got %b %h %b %b want 1 ffffffff 0 0", rv1, res1, ro1, rz1); end
      rr1 = 1'b1;
      @(posedge clk); #1;
      rr1 = 1'b0;
      total++; if ({rv1, cr1} !== 2'b01) begin bad++; $display("FAIL s1_done: got %b %b want 0 1", rv1, cr1); end
   endtask

   initial begin
      test_reset();
      test_add_latency();
      test_overflow_sticky();
      test_chain();
      test_backpressure();
      test_reset_mid();
      test_settle_one();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
